// File: rtl/serial_word_tx.sv
// serial_word_tx: MSB-first parallel-to-serial stage with a valid/ready load port.
// Define SERIALIZER_PARITY_EN to append one even-parity bit after every word.
module serial_word_tx #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  serial_out,
  output logic                  serial_active,
  output logic                  word_done
);

  localparam int              CNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_q, out_d;
  logic                    active_q, active_d;
  logic                    last_bit;
  logic                    xfer;

  // Final bit of a word is on the line: last data bit, or the parity bit.
`ifdef SERIALIZER_PARITY_EN
  logic par_q, par_d;
  assign last_bit = (state_q == S_PARITY);
`else
  assign last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_MAX);
`endif

  assign load_ready    = (state_q == S_IDLE) || last_bit;
  assign word_done     = last_bit;
  assign xfer          = load_valid && load_ready;
  assign serial_out    = out_q;
  assign serial_active = active_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CNT_MAX) begin
`ifdef SERIALIZER_PARITY_EN
        state_d = S_PARITY;
`else
        state_d = xfer ? S_SHIFT : S_IDLE;
`endif
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: state_d = xfer ? S_SHIFT : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // A transfer always reloads, whether from IDLE or gapless off the final bit.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    active_d = active_q;
`ifdef SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif
    if (xfer) begin
      shift_d  = load_data;
      cnt_d    = '0;
      out_d    = load_data[DATA_WIDTH-1];
      active_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par_d    = ^load_data;
`endif
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (cnt_q != CNT_MAX) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            out_d   = shift_q[DATA_WIDTH-2];
          end else begin
`ifdef SERIALIZER_PARITY_EN
            out_d    = par_q;
`else
            out_d    = IDLE_LEVEL;
            active_d = 1'b0;
            cnt_d    = '0;
`endif
          end
        end
`ifdef SERIALIZER_PARITY_EN
        S_PARITY: begin
          out_d    = IDLE_LEVEL;
          active_d = 1'b0;
          cnt_d    = '0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      out_q    <= IDLE_LEVEL;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      active_q <= active_d;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: expected bit stream queued per accepted
// word, popped and compared by an independent monitor on every falling edge.
module tb_serial_word_tx;
  localparam int DW = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] load_data = '0;
  logic          load_valid = 1'b0;
  logic          load_ready, serial_out, serial_active, word_done;

  serial_word_tx #(.DATA_WIDTH(DW), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .serial_out(serial_out),
    .serial_active(serial_active), .word_done(word_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic b; logic last; } exp_t;
  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   mon_en  = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a word is its bits MSB first, optionally followed by XOR of all bits.
  function automatic void push_word(input logic [DW-1:0] w);
    exp_t e;
    for (int i = DW - 1; i >= 0; i--) begin
      e.b    = w[i];
      e.last = (i == 0) && !PAR;
      sb.push_back(e);
    end
    if (PAR) begin
      e.b    = ^w;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (sb.size() == 0) begin
        check("idle_active", serial_active, 1'b0);
        check("idle_out", serial_out, 1'b0);
        check("idle_ready", load_ready, 1'b1);
        check("idle_done", word_done, 1'b0);
      end else begin
        e = sb.pop_front();
        check("active", serial_active, 1'b1);
        check("bit", serial_out, e.b);
        check("word_done", word_done, e.last);
        check("load_ready", load_ready, e.last);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Holds the word with valid high until accepted; caller sits at negedge+1.
  task automatic send(input logic [DW-1:0] w);
    int n = 0;
    load_data  = w;
    load_valid = 1'b1;
    while (!load_ready && n < 100) begin
      step();
      n++;
    end
    if (!load_ready) begin
      check("send_timeout", 1'b0, 1'b1);
    end else begin
      push_word(w);
      step();
    end
    load_valid = 1'b0;
    load_data  = DW'($urandom);
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    // Reset held with the clock running.
    repeat (2) @(negedge clk);
    check("rst_out", serial_out, 1'b0);
    check("rst_active", serial_active, 1'b0);
    check("rst_ready", load_ready, 1'b1);
    check("rst_done", word_done, 1'b0);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    idle(3);

    send(8'hD0);
    idle(DW + 3);

    send(8'hD5);
    send(8'h3C);
    idle(DW + 3);

    // Second word waits with valid high through the first word's busy cycles.
    send(8'hA5);
    send(8'hFF);
    idle(DW + 3);

    if (PAR) begin
      send(8'hC3);
      idle(DW + 3);
    end

    // Abort mid-word: reset lands during the fourth bit.
    send(8'hAA);
    repeat (3) step();
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("abort_out", serial_out, 1'b0);
    check("abort_active", serial_active, 1'b0);
    check("abort_ready", load_ready, 1'b1);
    check("abort_done", word_done, 1'b0);
    sb.delete();
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    idle(DW + 2);

    // Random traffic: valid toggles freely, data changes every cycle.
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 99) < 60);
      load_data  = DW'($urandom);
      if (load_valid && load_ready) push_word(load_data);
      step();
    end
    idle(DW + 4);
    check("drain", (sb.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
